// File: rtl/zeroriscy_instr_port_arbiter_if.sv
// Handshake bundle between the two instruction-port masters, the arbiter and memory.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface zeroriscy_instr_port_arbiter_if;
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_gnt_o;
  logic        fetch_rvalid_o;
  logic [31:0] fetch_rdata_o;

  logic        dbg_req_i;
  logic [31:0] dbg_addr_i;
  logic        dbg_gnt_o;
  logic        dbg_rvalid_o;
  logic [31:0] dbg_rdata_o;

  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;

  modport slave (
    input  fetch_req_i, fetch_addr_i,
    output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
    input  dbg_req_i, dbg_addr_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    output instr_req_o, instr_addr_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i
  );

  modport master (
    output fetch_req_i, fetch_addr_i,
    input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
    output dbg_req_i, dbg_addr_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    input  instr_req_o, instr_addr_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i
  );
endinterface

// File: rtl/zeroriscy_instr_port_arbiter.sv
// Shares one instruction-memory port between fetch (F) and debug (D) with an in-order ID FIFO.
// Define ZERORISCY_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority D over F.
module zeroriscy_instr_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  zeroriscy_instr_port_arbiter_if.slave  bus,
  output logic                           busy_o,
  output logic                           err_o
);

  typedef enum logic {S_IDLE, S_HOLD} state_e;
  typedef enum logic {ID_F, ID_D} id_e;

  state_e      state_q, state_d;
  id_e         lock_q, lock_d;
  id_e         sel;
  id_e         head;
  id_e         fifo_q [4];
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        req;
  logic        drop;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        stray_rvalid;

`ifdef ZERORISCY_ARB_ROUND_ROBIN_EN
  id_e         last_q, last_d;
`endif

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign full  = (cnt_q == 3'(MAX_OUTSTANDING));
  assign empty = (cnt_q == 3'd0);
  assign head  = fifo_q[rd_ptr_q];

  // Lock FSM and arbitration; HOLD forwards only the locked master until granted.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    sel     = ID_F;
    req     = 1'b0;
    drop    = 1'b0;
    if (state_q == S_HOLD) begin
      sel  = lock_q;
      req  = (lock_q == ID_D) ? bus.dbg_req_i : bus.fetch_req_i;
      drop = ~req;
      if (drop || bus.instr_gnt_i) begin
        state_d = S_IDLE;
      end
    end else begin
      if (bus.dbg_req_i && bus.fetch_req_i) begin
`ifdef ZERORISCY_ARB_ROUND_ROBIN_EN
        sel = (last_q == ID_D) ? ID_F : ID_D;
`else
        sel = ID_D;
`endif
      end else if (bus.dbg_req_i) begin
        sel = ID_D;
      end else begin
        sel = ID_F;
      end
      // Full gates the request with registered state only, so rvalid never reaches req.
      req = (bus.fetch_req_i | bus.dbg_req_i) & ~full;
      if (req && !bus.instr_gnt_i) begin
        state_d = S_HOLD;
        lock_d  = sel;
      end
    end
  end

  assign bus.instr_req_o  = req & ~rst;
  assign bus.instr_addr_o = bus.instr_req_o ? ((sel == ID_D) ? bus.dbg_addr_i : bus.fetch_addr_i)
                                            : '0;

  assign push = bus.instr_req_o & bus.instr_gnt_i;
  assign bus.fetch_gnt_o = push & (sel == ID_F);
  assign bus.dbg_gnt_o   = push & (sel == ID_D);

  assign pop          = bus.instr_rvalid_i & ~empty & ~rst;
  assign stray_rvalid = bus.instr_rvalid_i & empty;
  assign bus.fetch_rvalid_o = pop & (head == ID_F);
  assign bus.dbg_rvalid_o   = pop & (head == ID_D);
  assign bus.fetch_rdata_o  = rst ? '0 : bus.instr_rdata_i;
  assign bus.dbg_rdata_o    = rst ? '0 : bus.instr_rdata_i;

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | stray_rvalid | drop;
  end

`ifdef ZERORISCY_ARB_ROUND_ROBIN_EN
  always_comb begin
    last_d = last_q;
    if (push) begin
      last_d = sel;
    end
  end
`endif

  assign busy_o = ~rst & (~empty | (state_q == S_HOLD));
  assign err_o  = ~rst & err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lock_q   <= ID_F;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        fifo_q[i] <= ID_F;
      end
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= sel;
      end
    end
  end

`ifdef ZERORISCY_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= ID_D;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule
